chip8_memory_ctrl: RTL and testbench

Parametrised successor to the CHIP-8 main RAM. It provides a single-clock RAM with one read port and one write port, generalised in data width and depth. It adds a self-initialisation engine that runs after reset: it zero-clears the whole array, then preloads the standard 80-byte CHIP-8 hex font. It also adds a read-valid handshake, a selectable read-during-write mode, and safe out-of-range handling. It sits between the CPU core, the display fetcher and the ROM loader.

---
 rtl/chip8_memory_ctrl_if.sv | 30 +++
 rtl/chip8_memory_ctrl.sv | 171 +++++++++++++++++
 tb/tb_chip8_memory_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_memory_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : chip8_memory_ctrl_if
// Description : Read/write request bus between clients and chip8_memory_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface chip8_memory_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  ready;
    logic                  read;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  write;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;

    modport master (
        input  ready, read_data, read_valid,
        output read, read_addr, write, write_addr, write_data
    );

    modport slave (
        output ready, read_data, read_valid,
        input  read, read_addr, write, write_addr, write_data
    );
endinterface
`default_nettype wire

// File: rtl/chip8_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : chip8_memory_ctrl
// Description : CHIP-8 main RAM with self-clear, font preload and read-valid.
// Revision    : 1.0 - initial release
// ============================================================================
module chip8_memory_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MEMORY_SIZE = 4096,
    parameter bit          FONT_ENABLE = 1'b1,
    parameter int unsigned FONT_BASE   = 'h050,
    parameter bit          RDW_MODE    = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    chip8_memory_ctrl_if.slave bus
);
    localparam int unsigned c_IDX_W    = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
    localparam int unsigned c_FONT_LEN = 80;

    localparam logic [ADDR_WIDTH-1:0] c_LAST_WORD = ADDR_WIDTH'(MEMORY_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_FONT = ADDR_WIDTH'(c_FONT_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] c_FONT_BASE = ADDR_WIDTH'(FONT_BASE);
    localparam logic [ADDR_WIDTH:0]   c_SIZE_EXT  = (ADDR_WIDTH + 1)'(MEMORY_SIZE);

    localparam logic [7:0] c_FONT [0:79] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,   // 0
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,   // 1
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,   // 2
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,   // 3
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,   // 4
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,   // 5
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,   // 6
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,   // 7
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,   // 8
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,   // 9
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,   // A
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,   // B
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,   // C
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,   // D
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,   // E
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80    // F
    };

    generate
        if (DATA_WIDTH < 8) begin : g_err_data_width
            $error("chip8_memory_ctrl: DATA_WIDTH must be >= 8");
        end
        if (MEMORY_SIZE > (64'd1 << ADDR_WIDTH)) begin : g_err_mem_size
            $error("chip8_memory_ctrl: MEMORY_SIZE exceeds address space");
        end
        if (FONT_BASE + c_FONT_LEN > MEMORY_SIZE) begin : g_err_font_base
            $error("chip8_memory_ctrl: font does not fit in memory");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_FONT  = 2'd1,
        S_IDLE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_next;

    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    logic [DATA_WIDTH-1:0] r_mem [0:MEMORY_SIZE-1];
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_read_valid;

    logic w_ready;
    logic w_rd_in_range;
    logic w_wr_in_range;
    logic w_rd_accept;
    logic w_wr_accept;

    assign w_ready       = (r_state == S_IDLE);
    assign w_rd_in_range = ({1'b0, bus.read_addr}  < c_SIZE_EXT);
    assign w_wr_in_range = ({1'b0, bus.write_addr} < c_SIZE_EXT);
    assign w_rd_accept   = w_ready && bus.read;
    assign w_wr_accept   = w_ready && bus.write && w_wr_in_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The single write port is shared: init engine owns it until IDLE.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        case (r_state)
            S_CLEAR: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_cnt;
                if (r_cnt == c_LAST_WORD) begin
                    w_cnt_next   = '0;
                    w_state_next = FONT_ENABLE ? S_FONT : S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_FONT: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = c_FONT_BASE + r_cnt;
                w_mem_wdata = DATA_WIDTH'(c_FONT[r_cnt[6:0]]);
                if (r_cnt == c_LAST_FONT) begin
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (w_wr_accept) begin
                    w_mem_we    = 1'b1;
                    w_mem_addr  = bus.write_addr;
                    w_mem_wdata = bus.write_data;
                end
            end
            default: begin
                w_state_next = S_CLEAR;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && w_mem_we) begin
            r_mem[w_mem_addr[c_IDX_W-1:0]] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
        end else begin
            r_read_valid <= w_rd_accept;
            if (w_rd_accept) begin
                if (!w_rd_in_range) begin
                    r_read_data <= '0;
                end else if (RDW_MODE && w_wr_accept && (bus.write_addr == bus.read_addr)) begin
                    r_read_data <= bus.write_data;
                end else begin
                    r_read_data <= r_mem[bus.read_addr[c_IDX_W-1:0]];
                end
            end
        end
    end

    assign bus.ready      = w_ready;
    assign bus.read_data  = r_read_data;
    assign bus.read_valid = r_read_valid;

endmodule
`default_nettype wire

// File: tb/tb_chip8_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_chip8_memory_ctrl
// Description : Directed bench for three chip8_memory_ctrl variants in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chip8_memory_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // bus0: defaults, bus1: RDW_MODE=1, bus2: MEMORY_SIZE=3584
    chip8_memory_ctrl_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus0 ();
    chip8_memory_ctrl_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus1 ();
    chip8_memory_ctrl_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus2 ();

    chip8_memory_ctrl #(.RDW_MODE(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    chip8_memory_ctrl #(.RDW_MODE(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    chip8_memory_ctrl #(.MEMORY_SIZE(3584)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    task automatic drive(input logic rd, input logic [11:0] ra, input logic wr,
                         input logic [11:0] wa, input logic [7:0] wd);
        bus0.read = rd; bus0.read_addr = ra; bus0.write = wr; bus0.write_addr = wa; bus0.write_data = wd;
        bus1.read = rd; bus1.read_addr = ra; bus1.write = wr; bus1.write_addr = wa; bus1.write_data = wd;
        bus2.read = rd; bus2.read_addr = ra; bus2.write = wr; bus2.write_addr = wa; bus2.write_data = wd;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        drive(1'b0, 12'h0, 1'b0, 12'h0, 8'h0);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] a);
        drive(1'b1, a, 1'b0, 12'h0, 8'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 12'h0, 1'b0, 12'h0, 8'h0);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [7:0] d);
        drive(1'b0, 12'h0, 1'b1, a, d);
        @(posedge clk);
        #1;
        drive(1'b0, 12'h0, 1'b0, 12'h0, 8'h0);
    endtask

    // Counts edges after reset release until each instance reports ready.
    task automatic wait_init(input bit poke, input string tag);
        int lat0, lat1, lat2;
        bit saw_valid;
        lat0 = -1; lat1 = -1; lat2 = -1; saw_valid = 1'b0;
        for (int c = 1; c <= 6000; c++) begin
            @(posedge clk);
            #1;
            if (lat0 < 0 && bus0.ready) lat0 = c;
            if (lat1 < 0 && bus1.ready) lat1 = c;
            if (lat2 < 0 && bus2.ready) lat2 = c;
            if ((!bus0.ready && bus0.read_valid) || (!bus1.ready && bus1.read_valid) ||
                (!bus2.ready && bus2.read_valid)) saw_valid = 1'b1;
            if (poke && c < 100) drive(1'b1, 12'h050, 1'b1, 12'h210, 8'h99);
            else                 drive(1'b0, 12'h0, 1'b0, 12'h0, 8'h0);
            if (lat0 >= 0 && lat1 >= 0 && lat2 >= 0) break;
        end
        checks++;
        if (lat0 !== 4176) begin errors++; $display("FAIL %s latency dut0: got %0d expected 4176", tag, lat0); end
        checks++;
        if (lat1 !== 4176) begin errors++; $display("FAIL %s latency dut1: got %0d expected 4176", tag, lat1); end
        checks++;
        if (lat2 !== 3664) begin errors++; $display("FAIL %s latency dut2: got %0d expected 3664", tag, lat2); end
        checks++;
        if (saw_valid !== 1'b0) begin errors++; $display("FAIL %s read_valid while not ready: got 1 expected 0", tag); end
    endtask

    task automatic test_reset;
        drive(1'b0, 12'h0, 1'b0, 12'h0, 8'h0);
        do_reset(2);
        checks++;
        if ({bus0.ready, bus1.ready, bus2.ready} !== 3'b000) begin
            errors++; $display("FAIL reset ready: got %b expected 000", {bus0.ready, bus1.ready, bus2.ready});
        end
        checks++;
        if ({bus0.read_valid, bus1.read_valid, bus2.read_valid} !== 3'b000) begin
            errors++; $display("FAIL reset read_valid: got %b expected 000", {bus0.read_valid, bus1.read_valid, bus2.read_valid});
        end
        checks++;
        if (bus0.read_data !== 8'h00) begin errors++; $display("FAIL reset read_data: got %h expected 00", bus0.read_data); end
        wait_init(1'b1, "init");
    endtask

    task automatic test_font;
        logic [11:0] addrs [10];
        logic [7:0]  exp   [10];
        addrs = '{12'h050, 12'h051, 12'h052, 12'h053, 12'h054, 12'h09B, 12'h09C, 12'h09D, 12'h09E, 12'h09F};
        exp   = '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0, 8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, addrs[i], 1'b0, 12'h0, 8'h0);
            @(posedge clk);
            #1;
            checks++;
            if (bus0.read_valid !== 1'b1 || bus0.read_data !== exp[i] || bus2.read_data !== exp[i]) begin
                errors++;
                $display("FAIL font[%h]: got valid=%b d0=%h d2=%h expected valid=1 data=%h",
                         addrs[i], bus0.read_valid, bus0.read_data, bus2.read_data, exp[i]);
            end
        end
        drive(1'b0, 12'h0, 1'b0, 12'h0, 8'h0);
        do_read(12'h000);
        checks++;
        if (bus0.read_data !== 8'h00 || bus0.read_valid !== 1'b1) begin
            errors++; $display("FAIL mem[000]: got %h valid=%b expected 00 valid=1", bus0.read_data, bus0.read_valid);
        end
        do_read(12'hFFF);
        checks++;
        if (bus0.read_data !== 8'h00 || bus2.read_data !== 8'h00 || bus2.read_valid !== 1'b1) begin
            errors++; $display("FAIL mem[FFF]: got d0=%h d2=%h v2=%b expected 00 00 1",
                               bus0.read_data, bus2.read_data, bus2.read_valid);
        end
        do_read(12'h210);
        checks++;
        if (bus0.read_data !== 8'h00 || bus1.read_data !== 8'h00 || bus2.read_data !== 8'h00) begin
            errors++; $display("FAIL write-while-not-ready 210: got %h %h %h expected 00",
                               bus0.read_data, bus1.read_data, bus2.read_data);
        end
    endtask

    task automatic test_write_read;
        do_write(12'h200, 8'hAB);
        checks++;
        if (bus0.read_valid !== 1'b0) begin errors++; $display("FAIL valid on write cycle: got %b expected 0", bus0.read_valid); end
        do_read(12'h200);
        checks++;
        if (bus0.read_valid !== 1'b1 || bus0.read_data !== 8'hAB) begin
            errors++; $display("FAIL read 200: got valid=%b data=%h expected 1 AB", bus0.read_valid, bus0.read_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus0.read_valid !== 1'b0 || bus0.read_data !== 8'hAB) begin
            errors++; $display("FAIL idle after read: got valid=%b data=%h expected 0 AB", bus0.read_valid, bus0.read_data);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vals [4];
        vals = '{8'h12, 8'h34, 8'h56, 8'h78};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 12'h0, 1'b1, 12'h500 + 12'(i), vals[i]);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 12'h500 + 12'(i), 1'b0, 12'h0, 8'h0);
            @(posedge clk);
            #1;
            checks++;
            if (bus0.read_valid !== 1'b1 || bus0.read_data !== vals[i]) begin
                errors++; $display("FAIL b2b read %0d: got valid=%b data=%h expected 1 %h",
                                   i, bus0.read_valid, bus0.read_data, vals[i]);
            end
        end
        drive(1'b0, 12'h0, 1'b0, 12'h0, 8'h0);
        @(posedge clk);
        #1;
        checks++;
        if (bus0.read_valid !== 1'b0) begin errors++; $display("FAIL b2b trailing valid: got %b expected 0", bus0.read_valid); end
    endtask

    task automatic test_rdw;
        drive(1'b1, 12'h300, 1'b1, 12'h300, 8'h5A);
        @(posedge clk);
        #1;
        drive(1'b0, 12'h0, 1'b0, 12'h0, 8'h0);
        checks++;
        if (bus0.read_data !== 8'h00 || bus0.read_valid !== 1'b1) begin
            errors++; $display("FAIL rdw mode0: got %h valid=%b expected 00 1", bus0.read_data, bus0.read_valid);
        end
        checks++;
        if (bus1.read_data !== 8'h5A || bus1.read_valid !== 1'b1) begin
            errors++; $display("FAIL rdw mode1: got %h valid=%b expected 5A 1", bus1.read_data, bus1.read_valid);
        end
        do_read(12'h300);
        checks++;
        if (bus0.read_data !== 8'h5A || bus1.read_data !== 8'h5A || bus2.read_data !== 8'h5A) begin
            errors++; $display("FAIL rdw reread: got %h %h %h expected 5A",
                               bus0.read_data, bus1.read_data, bus2.read_data);
        end
        drive(1'b1, 12'h050, 1'b1, 12'h301, 8'hC3);
        @(posedge clk);
        #1;
        drive(1'b0, 12'h0, 1'b0, 12'h0, 8'h0);
        checks++;
        if (bus1.read_data !== 8'hF0) begin errors++; $display("FAIL diff-addr rw read: got %h expected F0", bus1.read_data); end
        do_read(12'h301);
        checks++;
        if (bus1.read_data !== 8'hC3) begin errors++; $display("FAIL diff-addr rw write: got %h expected C3", bus1.read_data); end
    endtask

    task automatic test_out_of_range;
        do_write(12'hE00, 8'h11);
        do_read(12'hE00);
        checks++;
        if (bus0.read_data !== 8'h11) begin errors++; $display("FAIL in-range E00 dut0: got %h expected 11", bus0.read_data); end
        checks++;
        if (bus2.read_data !== 8'h00 || bus2.read_valid !== 1'b1) begin
            errors++; $display("FAIL oob E00 dut2: got %h valid=%b expected 00 1", bus2.read_data, bus2.read_valid);
        end
        do_read(12'h000);
        checks++;
        if (bus2.read_data !== 8'h00) begin errors++; $display("FAIL oob aliasing mem[000]: got %h expected 00", bus2.read_data); end
    endtask

    task automatic test_reset_mid;
        bit early;
        early = 1'b0;
        do_write(12'h400, 8'h77);
        do_read(12'h400);
        checks++;
        if (bus0.read_data !== 8'h77) begin errors++; $display("FAIL pre-reset 400: got %h expected 77", bus0.read_data); end
        do_reset(2);
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            if (bus0.ready || bus1.ready || bus2.ready) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin errors++; $display("FAIL ready during partial clear: got 1 expected 0"); end
        do_reset(1);
        wait_init(1'b0, "reinit");
        do_read(12'h400);
        checks++;
        if (bus0.read_data !== 8'h00 || bus1.read_data !== 8'h00 || bus2.read_data !== 8'h00) begin
            errors++; $display("FAIL post-reset 400: got %h %h %h expected 00",
                               bus0.read_data, bus1.read_data, bus2.read_data);
        end
        do_read(12'h054);
        checks++;
        if (bus0.read_data !== 8'hF0) begin errors++; $display("FAIL post-reset font 054: got %h expected F0", bus0.read_data); end
    endtask

    initial begin
        test_reset;
        test_font;
        test_write_read;
        test_back_to_back;
        test_rdw;
        test_out_of_range;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
